// File: rtl/tpu_pkg.sv
// tpu_pkg: shared widths and loader FSM encoding for the weight path.
//   ADDR_W     - weight memory address width
//   DATA_W     - width of one weight
//   CNT_W      - width of the tile count
//   TILE_BYTES - bytes per 2x2 tile, also the address stride between tiles
package tpu_pkg;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 8;
    localparam int TILE_BYTES = 4;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} loader_state_t;
endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: command, weight-memory and tile-output signals of the weight loader.
//   command : start, base_addr, num_tiles -> loader; busy, done <- loader
//   memory  : mem_addr <- loader; mem_weight1..4 -> loader (same-cycle read data)
//   tiles   : weight_out1..4, w_valid <- loader; w_ready -> loader
// The slave modport is the loader; the master modport is its surroundings.
interface weight_loader_if;
    import tpu_pkg::*;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_tiles;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_weight1, mem_weight2, mem_weight3, mem_weight4;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] weight_out1, weight_out2, weight_out3, weight_out4;
    logic              busy;
    logic              done;
    modport master (
        output start, base_addr, num_tiles, mem_weight1, mem_weight2, mem_weight3, mem_weight4, w_ready,
        input  mem_addr, w_valid, weight_out1, weight_out2, weight_out3, weight_out4, busy, done
    );
    modport slave (
        input  start, base_addr, num_tiles, mem_weight1, mem_weight2, mem_weight3, mem_weight4, w_ready,
        output mem_addr, w_valid, weight_out1, weight_out2, weight_out3, weight_out4, busy, done
    );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: walks a run of 2x2 weight tiles from memory and streams them out over valid/ready.
//   clk     - system clock, all state on the rising edge
//   reset_n - asynchronous active-low reset
//   bus     - weight_loader_if.slave: start/base_addr/num_tiles command, busy/done status,
//             mem_addr/mem_weight1..4 memory read port, weight_out1..4/w_valid/w_ready tile stream
module weight_loader
    import tpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    weight_loader_if.slave bus
);
    loader_state_t                 state_q, state_d;
    logic [ADDR_W-1:0]             ptr_q, ptr_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]              remaining_q, remaining_d;
    logic [3:0][DATA_W-1:0]        weight_q, weight_d;
    logic                          w_valid_q, w_valid_d;
    logic [ADDR_W-1:0]             ptr_next;
    logic                          accept;
    assign ptr_next = ptr_q + ADDR_W'(TILE_BYTES);
    assign accept   = w_valid_q && bus.w_ready;
    // mem_addr only moves on the edge entering FETCH, so it stays on the
    // current tile's address while that tile is held under backpressure.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        weight_d    = weight_q;
        w_valid_d   = w_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d       = bus.base_addr;
                    remaining_d = bus.num_tiles;
                    state_d     = (bus.num_tiles != '0) ? FETCH : DONE;
                    mem_addr_d  = (bus.num_tiles != '0) ? bus.base_addr : mem_addr_q;
                end
            end
            FETCH: begin
                weight_d  = {bus.mem_weight4, bus.mem_weight3, bus.mem_weight2, bus.mem_weight1};
                w_valid_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    w_valid_d   = 1'b0;
                    ptr_d       = ptr_next;
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? DONE : FETCH;
                    mem_addr_d  = (remaining_q == CNT_W'(1)) ? mem_addr_q : ptr_next;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            weight_q    <= '0;
            w_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            weight_q    <= weight_d;
            w_valid_q   <= w_valid_d;
        end
    end
    assign bus.mem_addr    = mem_addr_q;
    assign bus.w_valid     = w_valid_q;
    assign bus.weight_out1 = weight_q[0];
    assign bus.weight_out2 = weight_q[1];
    assign bus.weight_out3 = weight_q[2];
    assign bus.weight_out4 = weight_q[3];
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and randomized runs of weight_loader against a schedule/memory model.
module tb_weight_loader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] mem [8192];
    weight_loader_if bus ();
    weight_loader dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    assign bus.mem_weight1 = mem[bus.mem_addr];
    assign bus.mem_weight2 = mem[bus.mem_addr + 13'd1];
    assign bus.mem_weight3 = mem[bus.mem_addr + 13'd2];
    assign bus.mem_weight4 = mem[bus.mem_addr + 13'd3];
    function automatic logic [31:0] tile_exp(input logic [12:0] a);
        return {mem[a], mem[a + 13'd1], mem[a + 13'd2], mem[a + 13'd3]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, ".w_valid"}, 32'(bus.w_valid), 32'd0);
        chk({tag, ".weights"}, {bus.weight_out1, bus.weight_out2, bus.weight_out3, bus.weight_out4}, 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".done"}, 32'(bus.done), 32'd0);
    endtask
    // Called at a negedge in an idle cycle; returns at the negedge of the first idle cycle after done.
    // Tile k becomes valid at cycle rise[k] (its fetch is cycle rise[k]-1) and is accepted at the end
    // of cycle hs[k]; the next fetch follows immediately, and done is the cycle after the last accept.
    task automatic run_load(input logic [12:0] base, input logic [7:0] n, input int stall_tile,
                            input int stall_len, input bit rnd);
        int rise[$];
        int hs[$];
        int t;
        int s;
        int done_c;
        int kv;
        int fk;
        bit ev;
        logic [12:0] a;
        t = 2;
        for (int i = 0; i < int'(n); i++) begin
            s = (i == stall_tile) ? stall_len : (rnd ? int'($urandom_range(0, 3)) : 0);
            rise.push_back(t);
            hs.push_back(t + s);
            t = t + s + 2;
        end
        done_c = t - 1;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.num_tiles = n;
        bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            ev = 1'b0;
            kv = 0;
            fk = -1;
            foreach (rise[i]) begin
                if (c >= rise[i] && c <= hs[i]) begin
                    ev = 1'b1;
                    kv = i;
                end
                if (c == rise[i] - 1) fk = i;
            end
            chk("w_valid", 32'(bus.w_valid), 32'(ev));
            if (ev) begin
                a = base + 13'(4 * kv);
                chk("tile", {bus.weight_out1, bus.weight_out2, bus.weight_out3, bus.weight_out4}, tile_exp(a));
                chk("mem_addr_hold", 32'(bus.mem_addr), 32'(a));
            end
            if (fk >= 0) begin
                a = base + 13'(4 * fk);
                chk("mem_addr_fetch", 32'(bus.mem_addr), 32'(a));
            end
            chk("done", 32'(bus.done), 32'(c == done_c));
            chk("busy", 32'(bus.busy), 32'(c <= done_c));
            bus.w_ready = ev ? (c == hs[kv]) : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.start = (c <= done_c) && rnd && (c == 1 || $urandom_range(0, 1) == 1);
            bus.base_addr = 13'($urandom);
            bus.num_tiles = 8'($urandom_range(1, 255));
        end
        bus.start = 1'b0;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [12:0] b;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_tiles = '0;
        bus.w_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("first_tile_direct", tile_exp(13'd0), 32'h10111213);
        run_load(13'd0, 8'd1, -1, 0, 1'b0);
        run_load(13'd4, 8'd3, -1, 0, 1'b0);
        run_load(13'd4, 8'd3, 1, 5, 1'b0);
        run_load(13'($urandom), 8'd0, -1, 0, 1'b1);
        run_load(13'd8188, 8'd2, -1, 0, 1'b0);
        run_load(13'd8188, 8'd2, 0, 3, 1'b1);
        for (int r = 0; r < 8; r++) run_load(13'($urandom), 8'($urandom_range(0, 6)), -1, 0, 1'b1);
        b = 13'($urandom);
        bus.start = 1'b1;
        bus.base_addr = b;
        bus.num_tiles = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", 32'(bus.w_valid), 32'd1);
        chk("pre_reset_tile", {bus.weight_out1, bus.weight_out2, bus.weight_out3, bus.weight_out4}, tile_exp(b));
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("after_reset");
        run_load(13'd0, 8'd4, 2, 2, 1'b0);
        run_load(13'($urandom), 8'd5, -1, 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
